// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a burst of words from a FIFO and streams them out over valid/ready,
// hiding the FIFO's one-cycle read latency behind a 3-entry output buffer.
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             abort,
    output logic             fifo_rd_en,
    input  logic             fifo_empty,
    input  logic             fifo_rd_error,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
    state_t           state, state_nx;
    logic [LEN_W-1:0] remaining;
    logic             inflight, zero_done, accept, push, pop;
    logic [1:0]       occ, head, tail;
    logic [WIDTH-1:0] mem [3];

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    assign accept  = (state == IDLE) && start;
    assign push    = inflight && !fifo_rd_error;
    assign pop     = m_valid && m_ready;
    assign m_valid = occ != 2'd0;
    assign m_data  = mem[head];
    assign busy    = state != IDLE;

    // Credit counts buffered plus in-flight words so a read never overflows the buffer.
    always_comb begin
        state_nx   = state;
        fifo_rd_en = 1'b0;
        done       = zero_done;
        case (state)
            IDLE:  if (start && burst_len != '0) state_nx = READ;
            READ: begin
                fifo_rd_en = !abort && !fifo_empty && remaining != '0 &&
                             ({1'b0, occ} + {2'b0, inflight} <= 3'd2);
                if (remaining == '0 || abort) state_nx = FLUSH;
            end
            FLUSH: if (!inflight && occ == 2'd0) begin
                state_nx = IDLE;
                done     = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            inflight  <= 1'b0;
            zero_done <= 1'b0;
            err       <= 1'b0;
            occ       <= 2'd0;
            head      <= 2'd0;
            tail      <= 2'd0;
            for (int i = 0; i < 3; i++) mem[i] <= '0;
        end else begin
            state     <= state_nx;
            zero_done <= accept && burst_len == '0;
            inflight  <= fifo_rd_en;
            if (accept) remaining <= burst_len;
            else if (fifo_rd_en) remaining <= remaining - 1'b1;
            if (accept) err <= 1'b0;
            else if (inflight && fifo_rd_error) err <= 1'b1;
            if (push) begin
                mem[tail] <= fifo_rd_data;
                tail      <= nxt(tail);
            end
            if (pop) head <= nxt(head);
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed scenarios against a behavioural 16-deep FIFO model.
module tb_fifo_burst_reader;
    logic       clk = 0, rst = 0, start = 0, abort = 0, m_ready = 0;
    logic [7:0] burst_len = 0;
    logic       fifo_rd_en, fifo_empty, m_valid, busy, done, err;
    logic       fifo_rd_error = 0;
    logic [7:0] fifo_rd_data = 0, m_data;

    fifo_burst_reader #(.WIDTH(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .abort(abort),
        .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_rd_error(fifo_rd_error),
        .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic       wr_en = 0, flush_req = 0;
    logic [7:0] wr_data = 0;
    int         fcnt = 0, rd_idx = 0, err_at = -1;

    always @(posedge clk) begin
        if (flush_req) q.delete();
        if (fifo_rd_en && q.size() != 0) begin
            fifo_rd_data  <= q.pop_front();
            fifo_rd_error <= (rd_idx == err_at);
            rd_idx        <= rd_idx + 1;
        end else fifo_rd_error <= 1'b0;
        if (wr_en && q.size() < 16) q.push_back(wr_data);
        fcnt <= q.size();
    end
    assign fifo_empty = (fcnt == 0);

    int         cyc = 0, done_cnt = 0, rd_cnt = 0, viol_cnt = 0, last_done_cyc = 0;
    logic [7:0] got[$];
    int         got_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m_valid && m_ready) begin
            got.push_back(m_data);
            got_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (fifo_rd_en && fifo_empty) viol_cnt <= viol_cnt + 1;
    end

    int compared = 0, mismatched = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n, input int s, input int st);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1;
            wr_data = 8'(s + i * st);
            tick();
        end
        wr_en = 0;
    endtask

    task automatic start_burst(input int len);
        start     = 1;
        burst_len = 8'(len);
        tick();
        start = 0;
    endtask

    task automatic flush_fifo();
        flush_req = 1;
        tick();
        flush_req = 0;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        compared++;
        if (busy) begin
            mismatched++;
            $display("FAIL %s_timeout: busy still %b after %0d clks, want 0", name, busy, k);
        end
    endtask

    task automatic test_reset();
        compared++;
        if ({fifo_rd_en, m_valid, busy, done, err} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 00000", {fifo_rd_en, m_valid, busy, done, err});
        end
        compared++;
        if (m_data !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_m_data: got %0d want 0", m_data);
        end
    endtask

    task automatic test_full_burst();
        int g0, d0, n;
        logic [7:0] e;
        write_words(16, 0, 2);
        m_ready = 1;
        g0 = got.size();
        d0 = done_cnt;
        start_burst(16);
        compared++;
        if (m_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL full_valid_c0: got %b want 0", m_valid);
        end
        tick();
        compared++;
        if (m_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL full_valid_c1: got %b want 0", m_valid);
        end
        tick();
        compared++;
        if ({m_valid, m_data} !== {1'b1, 8'd0}) begin
            mismatched++;
            $display("FAIL full_first_word: got v=%b d=%0d want v=1 d=0", m_valid, m_data);
        end
        wait_idle("full");
        n = got.size() - g0;
        compared++;
        if (n != 16) begin
            mismatched++;
            $display("FAIL full_count: got %0d want 16", n);
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = 8'(2 * i);
                compared++;
                if (got[g0+i] !== e) begin
                    mismatched++;
                    $display("FAIL full_word%0d: got %0d want %0d", i, got[g0+i], e);
                end
            end
            compared++;
            if (got_cyc[g0+15] - got_cyc[g0] != 15) begin
                mismatched++;
                $display("FAIL full_span: got %0d clks want 15", got_cyc[g0+15] - got_cyc[g0]);
            end
            compared++;
            if (last_done_cyc != got_cyc[g0+15] + 1) begin
                mismatched++;
                $display("FAIL full_done_time: got cyc %0d want %0d", last_done_cyc, got_cyc[g0+15] + 1);
            end
        end
        compared++;
        if (done_cnt - d0 != 1 || fcnt != 0) begin
            mismatched++;
            $display("FAIL full_end: got done=%0d fifo=%0d want done=1 fifo=0", done_cnt - d0, fcnt);
        end
    endtask

    task automatic test_ready_toggle();
        int g0, d0, k;
        logic [7:0] e;
        write_words(16, 0, 2);
        g0 = got.size();
        d0 = done_cnt;
        m_ready = 1;
        start_burst(5);
        k = 0;
        while (busy && k < 200) begin
            m_ready = ~m_ready;
            tick();
            k++;
        end
        m_ready = 1;
        wait_idle("toggle");
        compared++;
        if (got.size() - g0 != 5) begin
            mismatched++;
            $display("FAIL toggle_count: got %0d want 5", got.size() - g0);
        end else
            for (int i = 0; i < 5; i++) begin
                e = 8'(2 * i);
                compared++;
                if (got[g0+i] !== e) begin
                    mismatched++;
                    $display("FAIL toggle_word%0d: got %0d want %0d", i, got[g0+i], e);
                end
            end
        compared++;
        if (fcnt != 11 || done_cnt - d0 != 1) begin
            mismatched++;
            $display("FAIL toggle_end: got fifo=%0d done=%0d want fifo=11 done=1", fcnt, done_cnt - d0);
        end
        flush_fifo();
    endtask

    task automatic test_starve();
        int g0, d0, v0;
        logic [7:0] e;
        g0 = got.size();
        d0 = done_cnt;
        v0 = viol_cnt;
        write_words(3, 10, 1);
        m_ready = 1;
        start_burst(6);
        repeat (20) tick();
        compared++;
        if (got.size() - g0 != 3 || {busy, fifo_rd_en} !== 2'b10) begin
            mismatched++;
            $display("FAIL starve_pause: got n=%0d busy/rd_en=%b want n=3 busy/rd_en=10",
                     got.size() - g0, {busy, fifo_rd_en});
        end
        write_words(3, 13, 1);
        wait_idle("starve");
        compared++;
        if (got.size() - g0 != 6) begin
            mismatched++;
            $display("FAIL starve_count: got %0d want 6", got.size() - g0);
        end else
            for (int i = 0; i < 6; i++) begin
                e = 8'(10 + i);
                compared++;
                if (got[g0+i] !== e) begin
                    mismatched++;
                    $display("FAIL starve_word%0d: got %0d want %0d", i, got[g0+i], e);
                end
            end
        compared++;
        if (done_cnt - d0 != 1 || viol_cnt != v0) begin
            mismatched++;
            $display("FAIL starve_end: got done=%0d empty_reads=%0d want done=1 empty_reads=0",
                     done_cnt - d0, viol_cnt - v0);
        end
    endtask

    task automatic test_backpressure();
        int g0, r0;
        logic [7:0] held, e;
        logic stable;
        write_words(16, 0, 2);
        g0 = got.size();
        m_ready = 1;
        start_burst(16);
        repeat (4) tick();
        m_ready = 0;
        held = m_data;
        compared++;
        if ({m_valid, held} !== {1'b1, 8'd4}) begin
            mismatched++;
            $display("FAIL bp_head: got v=%b d=%0d want v=1 d=4", m_valid, held);
        end
        repeat (3) tick();
        r0 = rd_cnt;
        stable = 1;
        repeat (7) begin
            tick();
            if (m_data !== held || m_valid !== 1'b1) stable = 0;
        end
        compared++;
        if (stable !== 1'b1 || rd_cnt != r0 || fifo_rd_en !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_stall: got stable=%b reads=%0d rd_en=%b want stable=1 reads=0 rd_en=0",
                     stable, rd_cnt - r0, fifo_rd_en);
        end
        m_ready = 1;
        wait_idle("bp");
        compared++;
        if (got.size() - g0 != 16) begin
            mismatched++;
            $display("FAIL bp_count: got %0d want 16", got.size() - g0);
        end else
            for (int i = 0; i < 16; i++) begin
                e = 8'(2 * i);
                compared++;
                if (got[g0+i] !== e) begin
                    mismatched++;
                    $display("FAIL bp_word%0d: got %0d want %0d", i, got[g0+i], e);
                end
            end
    endtask

    task automatic test_abort();
        int g0, d0, r0;
        logic [7:0] e;
        write_words(16, 0, 2);
        g0 = got.size();
        d0 = done_cnt;
        r0 = rd_cnt;
        m_ready = 1;
        start_burst(16);
        repeat (4) tick();
        abort = 1;
        tick();
        abort = 0;
        wait_idle("abort");
        compared++;
        if (got.size() - g0 != 4) begin
            mismatched++;
            $display("FAIL abort_count: got %0d want 4", got.size() - g0);
        end else
            for (int i = 0; i < 4; i++) begin
                e = 8'(2 * i);
                compared++;
                if (got[g0+i] !== e) begin
                    mismatched++;
                    $display("FAIL abort_word%0d: got %0d want %0d", i, got[g0+i], e);
                end
            end
        compared++;
        if (fcnt != 12 || rd_cnt - r0 != 4 || done_cnt - d0 != 1) begin
            mismatched++;
            $display("FAIL abort_end: got fifo=%0d reads=%0d done=%0d want fifo=12 reads=4 done=1",
                     fcnt, rd_cnt - r0, done_cnt - d0);
        end
        flush_fifo();
    endtask

    task automatic test_read_error();
        int g0;
        write_words(3, 40, 1);
        g0 = got.size();
        m_ready = 1;
        err_at = rd_idx + 1;
        start_burst(3);
        wait_idle("rderr");
        compared++;
        if (got.size() - g0 != 2) begin
            mismatched++;
            $display("FAIL rderr_count: got %0d want 2", got.size() - g0);
        end else begin
            compared++;
            if ({got[g0], got[g0+1]} !== {8'd40, 8'd42}) begin
                mismatched++;
                $display("FAIL rderr_words: got %0d,%0d want 40,42", got[g0], got[g0+1]);
            end
        end
        compared++;
        if (err !== 1'b1) begin
            mismatched++;
            $display("FAIL rderr_sticky: got %b want 1", err);
        end
        err_at = -1;
        write_words(1, 60, 1);
        start_burst(1);
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL rderr_clear: got %b want 0", err);
        end
        wait_idle("rderr2");
    endtask

    task automatic test_reset_mid();
        int d0, r0, g0;
        logic [7:0] e;
        write_words(16, 100, 1);
        m_ready = 0;
        start_burst(16);
        repeat (5) tick();
        d0 = done_cnt;
        rst = 0;
        #2;
        compared++;
        if ({fifo_rd_en, m_valid, busy, done, err, m_data} !== 13'd0) begin
            mismatched++;
            $display("FAIL rstmid_outputs: got rd=%b v=%b busy=%b done=%b err=%b d=%0d want all 0",
                     fifo_rd_en, m_valid, busy, done, err, m_data);
        end
        tick();
        rst = 1;
        flush_fifo();
        repeat (3) tick();
        compared++;
        if (done_cnt != d0) begin
            mismatched++;
            $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0);
        end
        d0 = done_cnt;
        r0 = rd_cnt;
        start_burst(0);
        compared++;
        if ({done, busy} !== 2'b10) begin
            mismatched++;
            $display("FAIL zero_done: got done/busy=%b want 10", {done, busy});
        end
        tick();
        compared++;
        if (done !== 1'b0 || done_cnt - d0 != 1 || rd_cnt != r0) begin
            mismatched++;
            $display("FAIL zero_after: got done=%b pulses=%0d reads=%0d want 0/1/0",
                     done, done_cnt - d0, rd_cnt - r0);
        end
        write_words(3, 50, 1);
        g0 = got.size();
        m_ready = 1;
        start_burst(3);
        wait_idle("rstmid");
        compared++;
        if (got.size() - g0 != 3) begin
            mismatched++;
            $display("FAIL rstmid_count: got %0d want 3", got.size() - g0);
        end else
            for (int i = 0; i < 3; i++) begin
                e = 8'(50 + i);
                compared++;
                if (got[g0+i] !== e) begin
                    mismatched++;
                    $display("FAIL rstmid_word%0d: got %0d want %0d", i, got[g0+i], e);
                end
            end
    endtask

    initial begin
        repeat (3) tick();
        test_reset();
        rst = 1;
        tick();
        test_full_burst();
        test_ready_toggle();
        test_starve();
        test_backpressure();
        test_abort();
        test_read_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
